// File: rtl/dff8_stim_chk.sv
// dff8_stim_chk: LFSR stimulus source and response checker for the 8-bit
// offset-range D flip-flop. Drives LE/BE data inputs, compares q/nq/be_q/be_nq
// one flop-delay later and counts mismatching vectors.
// Optional build macro DFF8_STIM_CHK_ERR_CAPTURE_EN adds first-error capture
// outputs (valid flag, vector index, per-bit mismatch mask).
//
// start_i is a single-cycle request with no ready: it is acted on only in
// IDLE or DONE and silently dropped while busy_o is high.
`timescale 1ns/1ps
module dff8_stim_chk #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    IOFF        = 3,
    parameter int                    OOFF        = 5,
    parameter int                    NUM_VECTORS = 256,
    parameter logic [DATA_WIDTH-1:0] SEED        = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] POLY        = 8'hB8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                pass_o,
    output logic [15:0]                         err_cnt_o,
    output logic [$clog2(NUM_VECTORS+1)-1:0]    vec_cnt_o,
    output logic [DATA_WIDTH-1+IOFF:IOFF]       d_o,
    output logic [IOFF:DATA_WIDTH-1+IOFF]       be_d_o,
    input  logic [DATA_WIDTH-1+OOFF:OOFF]       q_i,
    input  logic [DATA_WIDTH-1+OOFF:OOFF]       nq_i,
    input  logic [OOFF:DATA_WIDTH-1+OOFF]       be_q_i,
    input  logic [OOFF:DATA_WIDTH-1+OOFF]       be_nq_i
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
    ,
    output logic                                first_err_v_o,
    output logic [$clog2(NUM_VECTORS)-1:0]      first_err_idx_o,
    output logic [4*DATA_WIDTH-1:0]             first_err_mask_o
`endif
);

    localparam int VCW = $clog2(NUM_VECTORS+1);
    localparam int KW  = $clog2(NUM_VECTORS);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [DATA_WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : SEED;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_VECTORS-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  chk_v_q;
    logic [KW-1:0]         k_q, k_d;
    logic [15:0]           err_q, err_d;
    logic [VCW-1:0]        vec_q, vec_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                  err_hit;

    logic [DATA_WIDTH-1:0] mm_q, mm_nq, mm_bq, mm_bnq;
    logic                  vec_ok;

    // Per-bit mismatch against the expected vector; X/Z makes vec_ok unknown,
    // which the if/else below routes to the mismatch branch.
    always_comb begin
        mm_q   = '0;
        mm_nq  = '0;
        mm_bq  = '0;
        mm_bnq = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mm_q[i]   = q_i[OOFF+i]     ^ exp_q[i];
            mm_nq[i]  = nq_i[OOFF+i]    ^ ~exp_q[i];
            mm_bq[i]  = be_q_i[OOFF+i]  ^ exp_q[i];
            mm_bnq[i] = be_nq_i[OOFF+i] ^ ~exp_q[i];
        end
        vec_ok = ~|{mm_bnq, mm_bq, mm_nq, mm_q};
    end

    // Next-state, pattern generation and result counting.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        k_d     = k_q;
        err_d   = err_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_hit = 1'b0;

        if (chk_v_q) begin
            vec_d = vec_q + VCW'(1);
            if (vec_ok) begin
                err_d = err_q;
            end else begin
                err_hit = 1'b1;
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pat_d   = SEED_EFF;
                    k_d     = '0;
                    err_d   = '0;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d   = k_q + KW'(1);
                    pat_d = pat_q[0] ? ((pat_q >> 1) ^ POLY) : (pat_q >> 1);
                end
            end
            S_DRAIN: begin
                // The last vector is compared on this edge, so the final
                // counts and done_o appear together.
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == 16'd0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            exp_q   <= '0;
            chk_v_q <= 1'b0;
            k_q     <= '0;
            err_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            exp_q   <= pat_q;
            chk_v_q <= (state_q == S_RUN);
            k_q     <= k_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Stimulus fans out by bit index, so the ascending BE port gets the same
    // bit at the same index as the LE port.
    always_comb begin
        d_o    = '0;
        be_d_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d_o[IOFF+i]    = pat_q[i];
            be_d_o[IOFF+i] = pat_q[i];
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;
    assign vec_cnt_o = vec_q;

`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
    logic                    cap_v_q;
    logic [KW-1:0]           cap_idx_q;
    logic [4*DATA_WIDTH-1:0] cap_mask_q;
    logic                    run_start;

    assign run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

    // Capture the first failing vector of a run; cleared when a run starts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_v_q    <= 1'b0;
            cap_idx_q  <= '0;
            cap_mask_q <= '0;
        end else if (run_start) begin
            cap_v_q    <= 1'b0;
            cap_idx_q  <= '0;
            cap_mask_q <= '0;
        end else if (err_hit && !cap_v_q) begin
            cap_v_q    <= 1'b1;
            cap_idx_q  <= vec_q[KW-1:0];
            cap_mask_q <= {mm_bnq, mm_bq, mm_nq, mm_q};
        end
    end

    assign first_err_v_o    = cap_v_q;
    assign first_err_idx_o  = cap_idx_q;
    assign first_err_mask_o = cap_mask_q;
`endif

endmodule

// File: tb/tb_dff8_stim_chk.sv
// tb_dff8_stim_chk: directed bench for dff8_stim_chk with a behavioural model
// of the offset-range flop and selectable wiring faults between the two.
`timescale 1ns/1ps
module tb_dff8_stim_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [8:0]  vec_cnt;
    logic [10:3] d;
    logic [3:10] be_d;
    logic [12:5] q_in, nq_in;
    logic [5:12] be_q_in, be_nq_in;
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
    logic        fe_v;
    logic [7:0]  fe_idx;
    logic [31:0] fe_mask;
`endif

    int checks = 0;
    int errors = 0;
    int fault  = 0;   // 0 none, 1 q[5] stuck 0, 2 nq tied to q, 3 be_q reversed

    logic [12:5] fq;
    logic [5:12] fbq;

    always #5 clk = ~clk;

    dff8_stim_chk dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .pass_o    (pass),
        .err_cnt_o (err_cnt),
        .vec_cnt_o (vec_cnt),
        .d_o       (d),
        .be_d_o    (be_d),
        .q_i       (q_in),
        .nq_i      (nq_in),
        .be_q_i    (be_q_in),
        .be_nq_i   (be_nq_in)
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
        ,
        .first_err_v_o    (fe_v),
        .first_err_idx_o  (fe_idx),
        .first_err_mask_o (fe_mask)
`endif
    );

    // Offset-range flop: q[5+i] <= d[3+i], be_q[5+i] <= be_d[3+i].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq  <= '0;
            fbq <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                fq[5+i]  <= d[3+i];
                fbq[5+i] <= be_d[3+i];
            end
        end
    end

    // Flop-to-checker wiring, optionally broken.
    always_comb begin
        q_in     = fq;
        nq_in    = ~fq;
        be_q_in  = fbq;
        be_nq_in = ~fbq;
        case (fault)
            1: q_in[5] = 1'b0;
            2: nq_in = fq;
            3: for (int i = 0; i < 8; i++) be_q_in[5+i] = fbq[12-i];
            default: ;
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
    endfunction

    function automatic int count_non_palindromes();
        logic [7:0] p;
        int n;
        p = 8'hA5;
        n = 0;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (p[i] != p[7-i]) begin
                    n++;
                    break;
                end
            end
            p = lfsr_step(p);
        end
        return n;
    endfunction

    function automatic logic [7:0] be_val();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = be_d[3+i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves time just after the start edge s.
    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges until done_o is seen high, or -1 if it never rises.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, pass});
        end
        checks++;
        if ({err_cnt, vec_cnt} !== 25'd0) begin
            errors++;
            $display("FAIL reset_counts: got err %h vec %h expected 0", err_cnt, vec_cnt);
        end
        checks++;
        if (d !== 8'h00 || be_val() !== 8'h00) begin
            errors++;
            $display("FAIL reset_stim: got d %h be %h expected 00", d, be_val());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stimulus();
        int n;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'hA5;
        exp_v[1] = 8'hEA;
        exp_v[2] = 8'h75;
        fault = 0;
        start_run();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_flags: got busy %b done %b expected 1 0", busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d !== exp_v[k]) begin
                errors++;
                $display("FAIL le_vec%0d: got %h expected %h", k, d, exp_v[k]);
            end
            checks++;
            if (be_val() !== exp_v[k]) begin
                errors++;
                $display("FAIL be_vec%0d: got %h expected %h", k, be_val(), exp_v[k]);
            end
            if (k < 2) tick();
        end
        // done_o appears on edge s+N+1 = s+257; two edges already used.
        wait_done(n);
        checks++;
        if (n !== 255) begin
            errors++;
            $display("FAIL done_latency: got %0d expected 255", n);
        end
        checks++;
        if (vec_cnt !== 9'd256 || err_cnt !== 16'd0 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_result: got vec %0d err %0d pass %b busy %b expected 256 0 1 0",
                     vec_cnt, err_cnt, pass, busy);
        end
        // Vector 255 is the seed again after the 255-state period.
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL hold_last: got %h expected a5", d);
        end
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
        checks++;
        if (fe_v !== 1'b0) begin
            errors++;
            $display("FAIL cap_clean: got %b expected 0", fe_v);
        end
`endif
    endtask

    task automatic test_stuck_bit();
        int n;
        fault = 1;
        start_run();
        wait_done(n);
        checks++;
        if (n !== 257) begin
            errors++;
            $display("FAIL stuck_latency: got %0d expected 257", n);
        end
        checks++;
        if (err_cnt !== 16'd129 || pass !== 1'b0 || vec_cnt !== 9'd256) begin
            errors++;
            $display("FAIL stuck_result: got err %0d pass %b vec %0d expected 129 0 256",
                     err_cnt, pass, vec_cnt);
        end
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
        checks++;
        if (fe_v !== 1'b1 || fe_idx !== 8'd0 || fe_mask !== 32'h0000_0001) begin
            errors++;
            $display("FAIL stuck_capture: got v %b idx %0d mask %h expected 1 0 00000001",
                     fe_v, fe_idx, fe_mask);
        end
`endif
    endtask

    task automatic test_nq_tied();
        int n;
        fault = 2;
        start_run();
        wait_done(n);
        checks++;
        if (n !== 257 || err_cnt !== 16'd256 || pass !== 1'b0) begin
            errors++;
            $display("FAIL nq_tied: got lat %0d err %0d pass %b expected 257 256 0",
                     n, err_cnt, pass);
        end
    endtask

    task automatic test_be_reversed();
        int n;
        int exp_err;
        exp_err = count_non_palindromes();
        fault = 3;
        start_run();
        wait_done(n);
        checks++;
        if (n !== 257 || err_cnt !== 16'(exp_err) || pass !== 1'b0) begin
            errors++;
            $display("FAIL be_reversed: got lat %0d err %0d pass %b expected 257 %0d 0",
                     n, err_cnt, pass, exp_err);
        end
        fault = 0;
    endtask

    task automatic test_start_ignored();
        int n;
        fault = 0;
        start_run();
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 206) begin
            errors++;
            $display("FAIL start_ignored_latency: got %0d expected 206", n);
        end
        checks++;
        if (vec_cnt !== 9'd256 || err_cnt !== 16'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_result: got vec %0d err %0d pass %b expected 256 0 1",
                     vec_cnt, err_cnt, pass);
        end
        // Restart from DONE.
        start_run();
        checks++;
        if (d !== 8'hA5 || done !== 1'b0 || busy !== 1'b1 || vec_cnt !== 9'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart: got d %h done %b busy %b vec %0d err %0d expected a5 0 1 0 0",
                     d, done, busy, vec_cnt, err_cnt);
        end
        wait_done(n);
        checks++;
        if (n !== 257 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_run: got lat %0d pass %b expected 257 1", n, pass);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        fault = 1;
        start_run();
        repeat (100) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass} !== 3'b000 || err_cnt !== 16'd0 || vec_cnt !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got busy %b done %b pass %b err %0d vec %0d expected all 0",
                     busy, done, pass, err_cnt, vec_cnt);
        end
        checks++;
        if (d !== 8'h00 || be_val() !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_stim: got d %h be %h expected 00", d, be_val());
        end
`ifdef DFF8_STIM_CHK_ERR_CAPTURE_EN
        checks++;
        if (fe_v !== 1'b0 || fe_mask !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_cap: got v %b mask %h expected 0", fe_v, fe_mask);
        end
`endif
        repeat (3) tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got done %b busy %b expected 0 0", done, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        fault = 0;
        start_run();
        wait_done(n);
        checks++;
        if (n !== 257 || vec_cnt !== 9'd256 || pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL after_reset_run: got lat %0d vec %0d pass %b err %0d expected 257 256 1 0",
                     n, vec_cnt, pass, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stimulus();
        test_stuck_bit();
        test_nq_tied();
        test_be_reversed();
        test_start_ignored();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
